// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous data memory between two masters,
// M0 (CPU) and M1 (I/O loader / debug port).
//
// Ownership is round-robin with a bounded burst. While the other master is waiting, an
// owner gets at most MAX_BURST consecutive granted cycles. An uncontended owner may hold
// ownership indefinitely. Handoff between owners costs no bubble cycle. The first access
// from idle is granted one cycle after the request.
//
// Optional feature (compile-time macro MEM_ARB_LOCK_EN): adds m0_lock/m1_lock. While the
// owner's lock is high it keeps ownership, even with req low, and is never forced to hand
// off.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mX_req/we/addr/wdata        master X access request (held stable until mX_gnt)
//   mX_gnt                      master X access performed this cycle
//   mX_rvalid/rdata             master X read return, one cycle after a granted read
//   mX_lock                     (MEM_ARB_LOCK_EN only) master X holds ownership
//   mem_we/addr/data            memory command pins, all zero when nobody is granted
//   mem_in                      memory read data, one cycle after the read address
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

`ifdef MEM_ARB_LOCK_EN
    input  logic                  m0_lock,
    input  logic                  m1_lock,
`endif

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_in
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;
    // Count value at which the current granted cycle is the MAX_BURST-th one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e           state_q;
    logic             last_owner_q;
    logic [CNT_W-1:0] burst_cnt_q;
    logic             rv0_q;
    logic             rv1_q;

    logic lock0;
    logic lock1;

`ifdef MEM_ARB_LOCK_EN
    assign lock0 = m0_lock;
    assign lock1 = m1_lock;
`else
    assign lock0 = 1'b0;
    assign lock1 = 1'b0;
`endif

    // Grants depend only on registered ownership, so at most one can be high.
    assign m0_gnt = (state_q == StOwn0) & m0_req;
    assign m1_gnt = (state_q == StOwn1) & m1_req;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (m0_gnt) begin
            mem_we   = m0_we;
            mem_addr = m0_addr;
            mem_data = m0_wdata;
        end else if (m1_gnt) begin
            mem_we   = m1_we;
            mem_addr = m1_addr;
            mem_data = m1_wdata;
        end
    end

    // Read data is shared; each master qualifies it with its own rvalid.
    assign m0_rdata  = mem_in;
    assign m1_rdata  = mem_in;
    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;

    // Owner-relative view of the request lines.
    logic own_is1;
    logic own_req;
    logic own_lock;
    logic oth_req;
    logic burst_done;
    logic release_own;

    always_comb begin
        own_is1     = (state_q == StOwn1);
        own_req     = own_is1 ? m1_req : m0_req;
        own_lock    = own_is1 ? lock1 : lock0;
        oth_req     = own_is1 ? m0_req : m1_req;
        burst_done  = (burst_cnt_q >= CNT_LAST);
        // Leave when done, or when a granted MAX_BURST-th cycle meets a waiting master.
        release_own = ~own_lock & (~own_req | (oth_req & burst_done));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            rv0_q        <= 1'b0;
            rv1_q        <= 1'b0;
        end else begin
            rv0_q <= m0_gnt & ~m0_we;
            rv1_q <= m1_gnt & ~m1_we;
            case (state_q)
                StIdle: begin
                    if (m0_req && m1_req) begin
                        state_q <= last_owner_q ? StOwn0 : StOwn1;
                    end else if (m0_req) begin
                        state_q <= StOwn0;
                    end else if (m1_req) begin
                        state_q <= StOwn1;
                    end
                end
                StOwn0, StOwn1: begin
                    if (release_own) begin
                        last_owner_q <= own_is1;
                        burst_cnt_q  <= '0;
                        if (oth_req) begin
                            state_q <= own_is1 ? StOwn0 : StOwn1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (own_req && (burst_cnt_q != CNT_SAT)) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small behavioural memory and an ownership model.
module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_in;
`ifdef MEM_ARB_LOCK_EN
    logic          m0_lock = 1'b0, m1_lock = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef MEM_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_in(mem_in)
    );

    // Single-port synchronous memory, one cycle read latency.
    logic [DW-1:0] mem [64];
    logic          preload = 1'b1;

    function automatic logic [DW-1:0] init_val(input int i);
        logic [DW-1:0] v;
        v = DW'(i * 257) ^ 16'h5a5a;
        return (i == 5) ? 16'h1234 : v;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else begin
            if (mem_we) mem[mem_addr] <= mem_data;
            mem_in <= mem[mem_addr];
        end
    end

    // Scoreboard queues.
    typedef struct {
        logic          g0;
        logic          g1;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cyc_exp_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_exp_t;

    cyc_exp_t      exp_q[$];
    rd_exp_t       rd_q0[$];
    rd_exp_t       rd_q1[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;

    // Reference model: who owns the memory, how many grants it has had, who owned last.
    int            own = -1;
    int            held = 0;
    int            last = 1;
    logic [DW-1:0] ref_mem [64];
    bit            mg0, mg1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of master inputs, record the expected response, advance the model.
    task automatic step(input bit rst, input bit r0, input bit w0, input int a0, input int d0,
                        input bit r1, input bit w1, input int a1, input int d1,
                        input bit l0, input bit l1);
        cyc_exp_t e;
        int       x;
        bit       rx, ry, lx, leave;
        @(posedge clk);
        #1;
        cyc++;
        rst_n    = rst;
        m0_req   = r0; m0_we = w0; m0_addr = a0[AW-1:0]; m0_wdata = d0[DW-1:0];
        m1_req   = r1; m1_we = w1; m1_addr = a1[AW-1:0]; m1_wdata = d1[DW-1:0];
`ifdef MEM_ARB_LOCK_EN
        m0_lock  = l0;
        m1_lock  = l1;
`endif
        e.g0   = rst && own == 0 && r0;
        e.g1   = rst && own == 1 && r1;
        e.we   = 1'b0;
        e.addr = '0;
        e.data = '0;
        if (!rst) begin
            rd_q0.delete();
            rd_q1.delete();
        end
        if (e.g0) begin
            e.we = w0; e.addr = a0[AW-1:0]; e.data = d0[DW-1:0];
            if (w0) ref_mem[a0] = d0[DW-1:0];
            else    rd_q0.push_back('{cyc + 1, ref_mem[a0]});
        end else if (e.g1) begin
            e.we = w1; e.addr = a1[AW-1:0]; e.data = d1[DW-1:0];
            if (w1) ref_mem[a1] = d1[DW-1:0];
            else    rd_q1.push_back('{cyc + 1, ref_mem[a1]});
        end
        exp_q.push_back(e);
        mg0 = e.g0;
        mg1 = e.g1;
        if (!rst) begin
            own = -1; held = 0; last = 1;
        end else if (own < 0) begin
            if (r0 && r1) own = 1 - last;
            else if (r0)  own = 0;
            else if (r1)  own = 1;
        end else begin
            x  = own;
            rx = (x == 1) ? r1 : r0;
            ry = (x == 1) ? r0 : r1;
            lx = (x == 1) ? l1 : l0;
            if (rx) held++;
            leave = !lx && (!rx || (ry && held >= MB));
            if (leave) begin
                last = x;
                held = 0;
                own  = ry ? 1 - x : -1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One master requests alone until the model grants it.
    task automatic issue(input int m, input bit we, input int addr, input int data);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (m == 0) step(1, 1, we, addr, data, 0, 0, 0, 0, 0, 0);
            else        step(1, 0, 0, 0, 0, 1, we, addr, data, 0, 0);
            done = (m == 0) ? mg0 : mg1;
        end
    endtask

    bit pend[2];
    bit pw[2];
    int pa[2];
    int pd[2];
    bit lk[2];

    task automatic rand_phase(input int n, input int p0, input int p1, input int pdrop,
                              input bit use_lock);
        int p[2];
        p[0] = p0;
        p[1] = p1;
        for (int i = 0; i < n; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    if (int'($urandom_range(99)) < p[m]) begin
                        pend[m] = 1;
                        pw[m]   = bit'($urandom_range(1));
                        pa[m]   = int'($urandom_range(63));
                        pd[m]   = int'($urandom_range(65535));
                    end
                end else if (int'($urandom_range(99)) < pdrop) begin
                    pend[m] = 0;
                end
                if (use_lock && int'($urandom_range(99)) < 15) lk[m] = ~lk[m];
                if (!use_lock) lk[m] = 0;
            end
            step(1, pend[0], pw[0], pa[0], pd[0], pend[1], pw[1], pa[1], pd[1], lk[0], lk[1]);
            if (mg0) pend[0] = 0;
            if (mg1) pend[1] = 0;
        end
    endtask

    // Monitor: pops one expected cycle per clock and any read return due now.
    always @(negedge clk) begin
        cyc_exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("m0_gnt", m0_gnt, e.g0);
            check("m1_gnt", m1_gnt, e.g1);
            check("mem_we", mem_we, e.we);
            check("mem_addr", mem_addr, e.addr);
            check("mem_data", mem_data, e.data);
        end
        if (m0_rvalid) begin
            if (rd_q0.size() == 0 || rd_q0[0].due != cyc) begin
                check("m0_rvalid_unexpected", m0_rvalid, 0);
            end else begin
                check("m0_rvalid", m0_rvalid, 1);
                check("m0_rdata", m0_rdata, rd_q0[0].data);
                void'(rd_q0.pop_front());
            end
        end else if (rd_q0.size() > 0 && rd_q0[0].due <= cyc) begin
            check("m0_rvalid", m0_rvalid, 1);
            void'(rd_q0.pop_front());
        end
        if (m1_rvalid) begin
            if (rd_q1.size() == 0 || rd_q1[0].due != cyc) begin
                check("m1_rvalid_unexpected", m1_rvalid, 0);
            end else begin
                check("m1_rvalid", m1_rvalid, 1);
                check("m1_rdata", m1_rdata, rd_q1[0].data);
                void'(rd_q1.pop_front());
            end
        end else if (rd_q1.size() > 0 && rd_q1[0].due <= cyc) begin
            check("m1_rvalid", m1_rvalid, 1);
            void'(rd_q1.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; pw[m] = 0; pa[m] = 0; pd[m] = 0; lk[m] = 0;
        end
        // Reset with nobody requesting.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        preload = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Lone M0 read of the preloaded word at address 5.
        issue(0, 0, 5, 16'h0bad);
        idle(3);

        // Both masters hold requests: bursts of MB, forced handoffs, and a reset mid-burst.
        for (int i = 0; i < 24; i++) begin
            step(i != 14, 1, 0, 3 + (i % 4), i, 1, (i % 3) == 0, 7 + (i % 2), 16'h100 + i, 0, 0);
        end
        idle(3);

        // M1 writes, then M0 reads the same location back.
        issue(1, 1, 10, 16'hBEEF);
        issue(0, 0, 10, 0);
        idle(3);

`ifdef MEM_ARB_LOCK_EN
        // M1 takes ownership, locks it for 10 contended cycles, then releases.
        issue(1, 0, 20, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 21, 0, 1, 0, 22 + i, 0, 0, 1);
        step(1, 1, 0, 21, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 21, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
`endif

        rand_phase(600, 50, 50, 0, 0);
        rand_phase(600, 90, 90, 5, 0);
`ifdef MEM_ARB_LOCK_EN
        rand_phase(600, 30, 80, 10, 1);
`else
        rand_phase(600, 30, 80, 10, 0);
`endif
        // Reset again with traffic in flight, then a short run after it.
        step(0, 1, 0, 1, 0, 1, 0, 2, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0;
            lk[m] = 0;
        end
        rand_phase(200, 70, 70, 0, 0);
        idle(3);

        @(negedge clk);
        #1;
        check("rd_q0_drained", rd_q0.size(), 0);
        check("rd_q1_drained", rd_q1.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
